// File: rtl/node_t30_stack_pkg.sv
// Shared definitions for the node family: data width, port count,
// register codes used by the compute nodes, the stack-node state type and
// the round-robin port search helper.
package node_pkg;

    localparam int unsigned DATA_W    = 11;
    localparam int unsigned NUM_PORTS = 4;

    // Register codes shared with the compute nodes
    localparam logic [2:0] REG_ACC  = 3'd0;
    localparam logic [2:0] REG_NIL  = 3'd1;
    localparam logic [2:0] REG_ANY  = 3'd2;
    localparam logic [2:0] REG_LAST = 3'd3;
    localparam logic [2:0] REG_0    = 3'd4;
    localparam logic [2:0] REG_1    = 3'd5;
    localparam logic [2:0] REG_2    = 3'd6;
    localparam logic [2:0] REG_3    = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        CHECK = 2'd2
    } t_state;

    // First port at or after 'start' (wrapping) whose bit is set in 'req'.
    // Returns 'start' when no bit is set; callers gate on |req.
    function automatic logic [1:0] rr_next(input logic [NUM_PORTS-1:0] req,
                                           input logic [1:0]           start);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = start;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = start + 2'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/node_t30_stack_mem.sv
// Stack storage for node_t30_stack: DEPTH words of DATA_W bits, one write
// port, and a combinational read of the top entry (index count-1).
module node_stack_mem
    import node_pkg::*;
#(
    parameter int unsigned DEPTH = 15,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [CW-1:0]     wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [CW-1:0]     count,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Next memory contents: only the addressed word changes on a write
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (we && (wr_idx == CW'(i))) begin
                mem_d[i] = wr_data;
            end
        end
    end

    // Storage register; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    // Top-of-stack read: word count-1, zero when empty
    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (count == CW'(i + 1)) begin
                rd_data = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/node_t30_stack.sv
// Stack memory node: neighbours push by sending to it and pop by receiving
// from it over the 4-port ready/done handshake. Pushes are arbitrated
// round-robin; the top of stack is offered to one masked-in port at a time.
// Optional status outputs (level, sticky overflow) under NODE_T30_STATUS_EN.
module node_t30_stack
    import node_pkg::*;
#(
    parameter int unsigned          DEPTH     = 15,
    parameter logic [NUM_PORTS-1:0] PORT_MASK = 4'b1111
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] in0,
    input  logic signed [DATA_W-1:0] in1,
    input  logic signed [DATA_W-1:0] in2,
    input  logic signed [DATA_W-1:0] in3,
    input  logic [NUM_PORTS-1:0]     ready,
    input  logic [NUM_PORTS-1:0]     done,
    output logic signed [DATA_W-1:0] outData,
    output logic [NUM_PORTS-1:0]     recv,
    output logic [NUM_PORTS-1:0]     send
`ifdef NODE_T30_STATUS_EN
    ,
    output logic [7:0]               level,
    output logic                     overflow
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    t_state                 state_q, state_d;
    logic [CW-1:0]          count_q, count_d;
    logic [1:0]             push_ptr_q, push_ptr_d;
    logic [1:0]             pop_ptr_q, pop_ptr_d;
    logic [DATA_W-1:0]      out_data_q, out_data_d;
    logic [NUM_PORTS-1:0]   recv_q, recv_d;
    logic [NUM_PORTS-1:0]   send_q, send_d;

    logic [DATA_W-1:0]      in_arr [NUM_PORTS];
    logic [NUM_PORTS-1:0]   eligible;
    logic [1:0]             push_sel;
    logic [1:0]             offer_sel;
    logic [1:0]             check_next;
    logic                   can_push;
    logic                   mem_we;
    logic [DATA_W-1:0]      top_data;

    assign in_arr[0] = in0;
    assign in_arr[1] = in1;
    assign in_arr[2] = in2;
    assign in_arr[3] = in3;

    // A sender still holds ready in the cycle it sees our recv pulse, so
    // ports we have just consumed from are masked out for that cycle.
    assign eligible   = ready & PORT_MASK & ~recv_q;
    assign can_push   = (|eligible) && (count_q < CW'(DEPTH));
    assign push_sel   = rr_next(eligible, push_ptr_q);
    assign offer_sel  = rr_next(PORT_MASK, pop_ptr_q);
    assign check_next = rr_next(PORT_MASK, pop_ptr_q + 2'd1);

    node_stack_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .wr_idx  (count_q),
        .wr_data (in_arr[push_sel]),
        .count   (count_q),
        .rd_data (top_data)
    );

    // Next-state and output logic for IDLE / OFFER / CHECK
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        push_ptr_d = push_ptr_q;
        pop_ptr_d  = pop_ptr_q;
        out_data_d = out_data_q;
        recv_d     = '0;
        send_d     = send_q;
        mem_we     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (can_push) begin
                    mem_we           = 1'b1;
                    count_d          = count_q + 1'b1;
                    recv_d[push_sel] = 1'b1;
                    push_ptr_d       = push_sel + 2'd1;
                end else if ((count_q != '0) && (|PORT_MASK)) begin
                    pop_ptr_d  = offer_sel;
                    out_data_d = top_data;
                    send_d     = NUM_PORTS'(1) << offer_sel;
                    state_d    = OFFER;
                end
            end
            OFFER: begin
                state_d = CHECK;
            end
            CHECK: begin
                send_d = '0;
                if (done[pop_ptr_q]) begin
                    count_d = count_q - 1'b1;
                end
                pop_ptr_d = check_next;
                state_d   = IDLE;
            end
            default: begin
                send_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            push_ptr_q <= '0;
            pop_ptr_q  <= '0;
            out_data_q <= '0;
            recv_q     <= '0;
            send_q     <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            push_ptr_q <= push_ptr_d;
            pop_ptr_q  <= pop_ptr_d;
            out_data_q <= out_data_d;
            recv_q     <= recv_d;
            send_q     <= send_d;
        end
    end

    assign outData = out_data_q;
    assign recv    = recv_q;
    assign send    = send_q;

`ifdef NODE_T30_STATUS_EN
    logic overflow_q, overflow_d;

    // Sticky flag: a connected neighbour wanted to push while we were full
    always_comb begin
        overflow_d = overflow_q;
        if ((|(ready & PORT_MASK)) && (count_q == CW'(DEPTH))) begin
            overflow_d = 1'b1;
        end
    end

    // Overflow register, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign level    = 8'(count_q);
    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_node_t30_stack.sv
// Directed bench for node_t30_stack: reset, push/pop handshake, LIFO order,
// simultaneous pushes, full stack, masked port, unanswered offer rotation.
module tb_node_t30_stack;

    logic                    clk = 1'b0;
    logic                    rst;
    logic signed [10:0]      in0, in1, in2, in3;
    logic [3:0]              ready, done, ready_m, done_m;
    logic signed [10:0]      out_data, out_data_m;
    logic [3:0]              recv, send, recv_m, send_m;
`ifdef NODE_T30_STATUS_EN
    logic [7:0]              level, level_m;
    logic                    overflow, overflow_m;
`endif

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    node_t30_stack #(.DEPTH(15), .PORT_MASK(4'b1111)) dut (
        .clk(clk), .rst(rst), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .ready(ready), .done(done), .outData(out_data), .recv(recv), .send(send)
`ifdef NODE_T30_STATUS_EN
        , .level(level), .overflow(overflow)
`endif
    );

    node_t30_stack #(.DEPTH(15), .PORT_MASK(4'b0111)) dut_m (
        .clk(clk), .rst(rst), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .ready(ready_m), .done(done_m), .outData(out_data_m), .recv(recv_m), .send(send_m)
`ifdef NODE_T30_STATUS_EN
        , .level(level_m), .overflow(overflow_m)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int port, input logic signed [10:0] v);
        case (port)
            0: in0 = v;
            1: in1 = v;
            2: in2 = v;
            default: in3 = v;
        endcase
    endtask

    // Mid-cycle asynchronous reset; outputs must clear without a clock edge
    task automatic do_reset();
        ready = '0; done = '0; ready_m = '0; done_m = '0;
        #3 rst = 1'b1;
        #1;
        check("rst_outdata", 32'(out_data), 32'(0));
        check("rst_send", 32'(send), 32'(0));
        check("rst_recv", 32'(recv), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic push(input int port, input logic signed [10:0] v);
        bit got;
        set_in(port, v);
        ready[port] = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            step();
            if (recv[port]) got = 1'b1;
        end
        check("push_recv", 32'(recv), 32'(4'b0001 << port));
        ready[port] = 1'b0;
        step();
        check("push_recv_pulse", 32'(recv), 32'(0));
    endtask

    // Take the next fresh offer on whichever port it is made
    task automatic pop_any(input logic signed [10:0] exp);
        logic [3:0] s;
        int p;
        for (int c = 0; c < 10 && send != 4'b0; c++) step();
        for (int c = 0; c < 30 && send == 4'b0; c++) step();
        s = send;
        check("pop_onehot", 32'($onehot(s)), 32'(1));
        check("pop_data", 32'(out_data), 32'(exp));
        p = 0;
        for (int i = 0; i < 4; i++) if (s[i]) p = i;
        step();
        check("pop_hold", 32'(send), 32'(s));
        done[p] = 1'b1;
        step();
        done = '0;
        check("pop_clear", 32'(send), 32'(0));
    endtask

    task automatic expect_idle(input string tag, input int cycles);
        int busy;
        busy = 0;
        for (int c = 0; c < cycles; c++) begin
            step();
            if (send != 4'b0) busy++;
        end
        check(tag, 32'(busy), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, bad, n;
        logic [3:0] seq [8];
        logic [3:0] prev;
        int order [4];

        rst = 1'b1; ready = '0; done = '0; ready_m = '0; done_m = '0;
        in0 = '0; in1 = '0; in2 = '0; in3 = '0;
        @(negedge clk);
        rst = 1'b0;
        step();

        // Reset in the middle of an offer discards the stack
        push(0, 11'sd100);
        check("inflight_send", 32'(send), 32'(4'b0001));
        do_reset();
        expect_idle("empty_after_rst", 10);

        // Single push on port 1, popped by neighbour 0
        push(1, -11'sd5);
        check("first_offer_port", 32'(send), 32'(4'b0001));
        check("first_offer_data", 32'(out_data), 32'(-11'sd5));
        step();
        done[0] = 1'b1;
        step();
        done = '0;
        check("single_pop_clear", 32'(send), 32'(0));
        expect_idle("single_empty", 8);

        // LIFO order through port 2
        do_reset();
        push(2, 11'sd1);
        push(2, 11'sd2);
        push(2, 11'sd3);
        pop_any(11'sd3);
        pop_any(11'sd2);
        pop_any(11'sd1);
        expect_idle("lifo_empty", 8);

        // Simultaneous ready on ports 1 and 3
        do_reset();
        in1 = 11'sd7; in3 = 11'sd9;
        ready = 4'b1010;
        pulses = 0; bad = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (recv != 4'b0) begin
                if (!$onehot(recv)) bad++;
                if (pulses < 4) order[pulses] = (recv[3] ? 3 : recv[2] ? 2 : recv[1] ? 1 : 0);
                pulses++;
            end
            ready = ready & ~recv;
        end
        check("simul_pulses", 32'(pulses), 32'(2));
        check("simul_onehot_bad", 32'(bad), 32'(0));
        check("simul_first", 32'(order[0]), 32'(1));
        check("simul_second", 32'(order[1]), 32'(3));
        pop_any(11'sd9);
        pop_any(11'sd7);

        // Fill to DEPTH=15; 16th push blocks until a pop frees a slot
        do_reset();
        for (int i = 0; i < 15; i++) push(0, 11'(100 + i));
        in0 = -11'sd7;
        ready[0] = 1'b1;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (recv != 4'b0) pulses++;
        end
        check("full_no_recv", 32'(pulses), 32'(0));
`ifdef NODE_T30_STATUS_EN
        check("full_level", 32'(level), 32'(15));
        check("full_overflow", 32'(overflow), 32'(1));
`endif
        pop_any(11'sd114);
        for (int c = 0; c < 10 && recv == 4'b0; c++) step();
        check("full_late_recv", 32'(recv), 32'(4'b0001));
        ready[0] = 1'b0;
        pop_any(-11'sd7);
        for (int i = 13; i >= 0; i--) pop_any(11'(100 + i));
        expect_idle("drained_empty", 8);

        // Four pushes at once, then 12 cycles with nobody taking the offer
        do_reset();
        in0 = 11'sd1; in1 = 11'sd2; in2 = 11'sd3; in3 = 11'sd4;
        ready = 4'b1111;
        pulses = 0;
        for (int c = 0; c < 10 && ready != 4'b0; c++) begin
            step();
            if (recv != 4'b0) pulses++;
            ready = ready & ~recv;
        end
        check("quad_pulses", 32'(pulses), 32'(4));
        n = 0; bad = 0; prev = '0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (send != 4'b0 && out_data != 11'sd4) bad++;
            if (prev == 4'b0 && send != 4'b0 && n < 8) begin
                seq[n] = send;
                n++;
            end
            prev = send;
        end
        check("rot_count", 32'(n), 32'(4));
        check("rot_0", 32'(seq[0]), 32'(4'b0001));
        check("rot_1", 32'(seq[1]), 32'(4'b0010));
        check("rot_2", 32'(seq[2]), 32'(4'b0100));
        check("rot_3", 32'(seq[3]), 32'(4'b1000));
        check("rot_data_bad", 32'(bad), 32'(0));
        pop_any(11'sd4);
        pop_any(11'sd3);
        pop_any(11'sd2);
        pop_any(11'sd1);

        // Masked-out port 3 on the second instance
        do_reset();
        in3 = 11'sd9;
        ready_m = 4'b1000;
        pulses = 0; bad = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (recv_m != 4'b0) pulses++;
            if (send_m != 4'b0) bad++;
        end
        check("mask_no_recv", 32'(pulses), 32'(0));
        check("mask_no_send", 32'(bad), 32'(0));
        in2 = 11'sd33;
        ready_m[2] = 1'b1;
        for (int c = 0; c < 10 && recv_m == 4'b0; c++) step();
        check("mask_push_recv", 32'(recv_m), 32'(4'b0100));
        ready_m[2] = 1'b0;
        n = 0; bad = 0; pulses = 0; prev = '0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (send_m[3]) bad++;
            if (send_m != 4'b0 && out_data_m != 11'sd33) bad++;
            if (recv_m != 4'b0) pulses++;
            if (prev == 4'b0 && send_m != 4'b0 && n < 8) begin
                seq[n] = send_m;
                n++;
            end
            prev = send_m;
        end
        check("mask_bad", 32'(bad), 32'(0));
        check("mask_extra_recv", 32'(pulses), 32'(0));
        check("mask_rot_count", 32'(n), 32'(4));
        check("mask_rot_0", 32'(seq[0]), 32'(4'b0001));
        check("mask_rot_1", 32'(seq[1]), 32'(4'b0010));
        check("mask_rot_2", 32'(seq[2]), 32'(4'b0100));
        check("mask_rot_3", 32'(seq[3]), 32'(4'b0001));
`ifdef NODE_T30_STATUS_EN
        check("mask_level", 32'(level_m), 32'(1));
        check("mask_overflow", 32'(overflow_m), 32'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
